aq_cp0_atp_ctrl: RTL and testbench
==================================

// Module: aq_cp0_atp_ctrl
// PURPOSE
//  Parametrised address-translation-pointer CSR bank in CP0. Holds ATP_NUM satp-format registers (0=satp, 1=vsatp, ...).
//  Legalises MODE as WARL and forwards each committed write to the MMU over a req/ack handshake.
//  Stalls IUI while an update is outstanding, so later CSR writes and smcir ops never overtake it.
//  Successor of the single-satp CP0 protection CSR logic; sits between the IUI CSR decode and the MMU/DTU.
// PARAMETERS
//  ATP_NUM     2   number of ATP registers (1..4); index 0 is satp
//  ASID_WIDTH  16  implemented ASID bits, stored from wdata[44+ASID_WIDTH-1:44]; 1..16
//  PPN_WIDTH   28  implemented PPN bits, stored from wdata[PPN_WIDTH-1:0]; 1..44
//  SV48_EN     0   1: MODE=9 (Sv48) is legal
// PORTS
//  regs_clk              in   1           CSR clock
//  cpurst_b              in   1           reset; asynchronous, active-low
//  iui_regs_wdata        in   64          CSR write data
//  atp_local_en          in   ATP_NUM     one-hot write strobe, one bit per ATP
//  smcir_local_en_raw    in   1           smcir access request
//  mmu_cp0_cmplt         in   1           MMU has completed the smcir operation
//  mmu_cp0_atp_ack       in   1           MMU accepts the ATP update
//  cp0_mmu_atp_req       out  1           ATP update request to the MMU
//  cp0_mmu_atp_sel       out  SELW        index of the updated ATP; SELW = max(1, clog2(ATP_NUM))
//  cp0_mmu_atp_data      out  64          legalised value of the updated ATP
//  atp_value             out  64*ATP_NUM  read values; entry i is [64*i+63:64*i]
//  cp0_dtu_satp          out  64          = entry 0
//  regs_iui_atp_stall    out  1           ATP write is held off
//  regs_iui_smcir_stall  out  1           smcir access is held off
// BEHAVIOUR
//  Reset: all ATP fields 0 (MODE=Bare), FSM in IDLE, cp0_mmu_atp_req=0, sel=0, data=0, both stalls 0.
//  Register format:
//   {MODE[3:0], zero-extended ASID in [59:44], 16'b0 in [43:28], zero-extended PPN in [27:0] or wider}.
//   Unimplemented bits read 0.
//  WARL for wdata[63:60]:
//   - 0 and 8 are legal; 9 is legal only when SV48_EN=1.
//   - Any other value leaves MODE unchanged; ASID and PPN are still written.
//  Commit:
//   - A write to ATP i commits when atp_local_en[i]=1 and regs_iui_atp_stall=0.
//   - The register updates at that edge.
//   - More than one bit set in atp_local_en is illegal; the bench asserts against it.
//  FSM IDLE/REQ:
//   - IDLE + commit -> REQ. At the same edge, latch sel=i and data=legalised new value.
//   - REQ: cp0_mmu_atp_req=1; sel and data are held stable.
//   - REQ + mmu_cp0_atp_ack -> IDLE next edge; req deasserts.
//   - An ack that arrives on the first REQ cycle is honoured: 1-cycle handshake.
//   - Ack while in IDLE is ignored.
//  Latency: write edge -> req high in the next cycle; minimum 2 cycles from write to IDLE.
//  regs_iui_atp_stall = (|atp_local_en) & (state==REQ), combinational.
//   - A stalled write changes no state.
//   - IUI holds the strobe and data until the stall drops.
//   - The write then commits in the cycle in which ack returns the FSM to IDLE, i.e. the first cycle after that edge.
//  regs_iui_smcir_stall = smcir_local_en_raw & (!mmu_cp0_cmplt | state==REQ).
//   - smcir must not pass a pending ATP update.
//  Back-to-back writes: the second write stalls one or more cycles. No update is ever dropped or merged.
//  Reset mid-operation: the FSM returns to IDLE and req drops immediately (async); registers are cleared.
// STRUCTURE
//  Package aq_cp0_atp_pkg:
//   - MODE encodings BARE=4'd0, SV39=4'd8, SV48=4'd9;
//   - field LSB constants ASID_LSB=44, PPN_LSB=0;
//   - function atp_mode_legal(mode, sv48_en).
//  Sub-module aq_cp0_atp_reg, generate-instanced ATP_NUM times:
//   - one register with WARL MODE and masked ASID/PPN;
//   - outputs its legalised next value for the data latch.
//  Top level holds the FSM, sel/data latch, stall logic and output flattening.
// TESTING
//  1. Write satp 0x8000_1234_0000_0ABC, immediate ack.
//     -> satp=0x8000_1234_0000_0ABC; req high for 1 cycle; sel=0; data equals satp.
//  2. Write satp with MODE=0x5 while MODE=8.
//     -> MODE stays 8; ASID and PPN take the new values.
//  3. SV48_EN=0, write MODE=9 -> MODE unchanged. SV48_EN=1, same write -> MODE=9.
//  4. Ack delayed 5 cycles; write vsatp at cycle +1.
//     -> atp_stall high for 4 cycles; vsatp unchanged until the FSM is back in IDLE.
//     -> The vsatp write then commits in the cycle in which ack returns the FSM to IDLE (cycle after that edge).
//     -> A second req follows with sel=1.
//  5. smcir_raw=1, cmplt=1, FSM in REQ -> smcir_stall=1. After ack and IDLE, smcir_stall=0.
//  6. Assert cpurst_b=0 while req is pending.
//     -> req drops asynchronously; all ATP=0; after release, a fresh write handshakes normally.

Source files
------------

// File: rtl/aq_cp0_atp_pkg.sv
// Shared encodings and helpers for the CP0 address-translation-pointer CSR bank.
package aq_cp0_atp_pkg;

    localparam logic [3:0] MODE_BARE = 4'd0;
    localparam logic [3:0] MODE_SV39 = 4'd8;
    localparam logic [3:0] MODE_SV48 = 4'd9;

    localparam int MODE_LSB = 60;
    localparam int ASID_LSB = 44;
    localparam int PPN_LSB  = 0;

    typedef enum logic {
        ATP_IDLE = 1'b0,
        ATP_REQ  = 1'b1
    } atp_state_e;

    function automatic logic atp_mode_legal(input logic [3:0] mode, input logic sv48_en);
        return (mode == MODE_BARE) || (mode == MODE_SV39) || (sv48_en && (mode == MODE_SV48));
    endfunction

endpackage

// File: rtl/aq_cp0_atp_reg.sv
// One satp-format register: WARL MODE, ASID/PPN truncated to the implemented widths.
module aq_cp0_atp_reg
    import aq_cp0_atp_pkg::*;
#(
    parameter int ASID_WIDTH = 16,
    parameter int PPN_WIDTH  = 28,
    parameter int SV48_EN    = 0
) (
    input  logic        regs_clk,
    input  logic        cpurst_b,
    input  logic        we_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] nxt_o,
    output logic [63:0] val_o
);

    logic [3:0]            mode_q, mode_d;
    logic [ASID_WIDTH-1:0] asid_q, asid_d;
    logic [PPN_WIDTH-1:0]  ppn_q,  ppn_d;
    logic                  unused_wdata;

    // Illegal MODE keeps the old mode, but ASID/PPN are still taken from the write.
    always_comb begin
        mode_d = atp_mode_legal(wdata_i[MODE_LSB +: 4], SV48_EN != 0) ? wdata_i[MODE_LSB +: 4] : mode_q;
        asid_d = wdata_i[ASID_LSB +: ASID_WIDTH];
        ppn_d  = wdata_i[PPN_LSB +: PPN_WIDTH];
    end

    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            mode_q <= MODE_BARE;
            asid_q <= '0;
            ppn_q  <= '0;
        end else if (we_i) begin
            mode_q <= mode_d;
            asid_q <= asid_d;
            ppn_q  <= ppn_d;
        end
    end

    always_comb begin
        val_o                         = '0;
        val_o[MODE_LSB +: 4]          = mode_q;
        val_o[ASID_LSB +: ASID_WIDTH] = asid_q;
        val_o[PPN_LSB +: PPN_WIDTH]   = ppn_q;
        nxt_o                         = '0;
        nxt_o[MODE_LSB +: 4]          = mode_d;
        nxt_o[ASID_LSB +: ASID_WIDTH] = asid_d;
        nxt_o[PPN_LSB +: PPN_WIDTH]   = ppn_d;
    end

    assign unused_wdata = ^wdata_i;

endmodule

// File: rtl/aq_cp0_atp_ctrl.sv
// ATP CSR bank: per-register storage, IDLE/REQ update handshake to the MMU, IUI stalls.
module aq_cp0_atp_ctrl
    import aq_cp0_atp_pkg::*;
#(
    parameter int ATP_NUM    = 2,
    parameter int ASID_WIDTH = 16,
    parameter int PPN_WIDTH  = 28,
    parameter int SV48_EN    = 0,
    localparam int SELW      = (ATP_NUM > 1) ? $clog2(ATP_NUM) : 1
) (
    input  logic                  regs_clk,
    input  logic                  cpurst_b,
    input  logic [63:0]           iui_regs_wdata,
    input  logic [ATP_NUM-1:0]    atp_local_en,
    input  logic                  smcir_local_en_raw,
    input  logic                  mmu_cp0_cmplt,
    input  logic                  mmu_cp0_atp_ack,
    output logic                  cp0_mmu_atp_req,
    output logic [SELW-1:0]       cp0_mmu_atp_sel,
    output logic [63:0]           cp0_mmu_atp_data,
    output logic [64*ATP_NUM-1:0] atp_value,
    output logic [63:0]           cp0_dtu_satp,
    output logic                  regs_iui_atp_stall,
    output logic                  regs_iui_smcir_stall
);

    atp_state_e                 state_q, state_d;
    logic                       commit;
    logic [ATP_NUM-1:0]         we;
    logic [ATP_NUM-1:0][63:0]   nxt, val;
    logic [SELW-1:0]            sel_q, sel_d;
    logic [63:0]                data_q, data_d;

    // A write only lands while no update is outstanding, so ordering is preserved.
    assign regs_iui_atp_stall   = (|atp_local_en) & (state_q == ATP_REQ);
    assign commit               = (|atp_local_en) & ~regs_iui_atp_stall;
    assign we                   = atp_local_en & {ATP_NUM{commit}};
    assign regs_iui_smcir_stall = smcir_local_en_raw & (~mmu_cp0_cmplt | (state_q == ATP_REQ));

    for (genvar g = 0; g < ATP_NUM; g++) begin : g_atp
        aq_cp0_atp_reg #(
            .ASID_WIDTH (ASID_WIDTH),
            .PPN_WIDTH  (PPN_WIDTH),
            .SV48_EN    (SV48_EN)
        ) u_reg (
            .regs_clk (regs_clk),
            .cpurst_b (cpurst_b),
            .we_i     (we[g]),
            .wdata_i  (iui_regs_wdata),
            .nxt_o    (nxt[g]),
            .val_o    (val[g])
        );
        assign atp_value[64*g +: 64] = val[g];
    end

    assign cp0_dtu_satp = val[0];

    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) state_q <= ATP_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ATP_IDLE: if (commit)          state_d = ATP_REQ;
            ATP_REQ:  if (mmu_cp0_atp_ack) state_d = ATP_IDLE;
            default:                       state_d = ATP_IDLE;
        endcase
    end

    always_comb begin
        cp0_mmu_atp_req  = (state_q == ATP_REQ);
        cp0_mmu_atp_sel  = sel_q;
        cp0_mmu_atp_data = data_q;
    end

    // Capture the legalised value the selected register is about to take.
    always_comb begin
        sel_d  = sel_q;
        data_d = data_q;
        if (commit && (state_q == ATP_IDLE)) begin
            sel_d  = '0;
            data_d = '0;
            for (int i = 0; i < ATP_NUM; i++) begin
                if (atp_local_en[i]) begin
                    sel_d  = sel_d | SELW'(i);
                    data_d = data_d | nxt[i];
                end
            end
        end
    end

    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_aq_cp0_atp_ctrl.sv
// Bench for aq_cp0_atp_ctrl: vector table plus handshake/stall/reset sequences, MMU-side scoreboard.
module tb_aq_cp0_atp_ctrl;

    logic regs_clk = 1'b0;
    logic cpurst_b = 1'b0;
    always #5 regs_clk = ~regs_clk;

    // u0: two ATPs, full-width PPN, no Sv48.  u1: one ATP, narrow ASID, 28-bit PPN, Sv48 legal.
    logic [63:0]  wdata0 = '0, wdata1 = '0;
    logic [1:0]   en0 = '0;
    logic [0:0]   en1 = '0;
    logic         smcir0 = 1'b0, cmplt0 = 1'b1, ack0 = 1'b1;
    logic         smcir1 = 1'b0, cmplt1 = 1'b1, ack1 = 1'b1;
    logic         req0, req1, astall0, astall1, sstall0, sstall1;
    logic [0:0]   sel0, sel1;
    logic [63:0]  data0, data1, satp0, satp1, val1;
    logic [127:0] val0;

    aq_cp0_atp_ctrl #(.ATP_NUM(2), .ASID_WIDTH(16), .PPN_WIDTH(44), .SV48_EN(0)) u0 (
        .regs_clk(regs_clk), .cpurst_b(cpurst_b), .iui_regs_wdata(wdata0), .atp_local_en(en0),
        .smcir_local_en_raw(smcir0), .mmu_cp0_cmplt(cmplt0), .mmu_cp0_atp_ack(ack0),
        .cp0_mmu_atp_req(req0), .cp0_mmu_atp_sel(sel0), .cp0_mmu_atp_data(data0),
        .atp_value(val0), .cp0_dtu_satp(satp0),
        .regs_iui_atp_stall(astall0), .regs_iui_smcir_stall(sstall0));

    aq_cp0_atp_ctrl #(.ATP_NUM(1), .ASID_WIDTH(9), .PPN_WIDTH(28), .SV48_EN(1)) u1 (
        .regs_clk(regs_clk), .cpurst_b(cpurst_b), .iui_regs_wdata(wdata1), .atp_local_en(en1),
        .smcir_local_en_raw(smcir1), .mmu_cp0_cmplt(cmplt1), .mmu_cp0_atp_ack(ack1),
        .cp0_mmu_atp_req(req1), .cp0_mmu_atp_sel(sel1), .cp0_mmu_atp_data(data1),
        .atp_value(val1), .cp0_dtu_satp(satp1),
        .regs_iui_atp_stall(astall1), .regs_iui_smcir_stall(sstall1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { logic sel; logic [63:0] data; } sb_t;
    sb_t sbq[$];
    logic [63:0] exp_atp[2] = '{64'h0, 64'h0};

    // MMU side: every accepted handshake must match the oldest committed write.
    always @(negedge regs_clk) begin
        if (cpurst_b && req0 && ack0) begin
            if (sbq.size() == 0) chk("sb_unexpected_req", 64'd1, 64'd0);
            else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_sel", {63'b0, sel0}, {63'b0, e.sel});
                chk("sb_data", data0, e.data);
            end
        end
    end

    always @(negedge regs_clk) assert ($onehot0(en0)) else $error("multi-hot atp_local_en");

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct { int dut; int idx; logic [63:0] wdata; logic [63:0] exp; } vec_t;
    vec_t vt[9];

    // Called just after a rising edge; leaves the bench just after a rising edge, FSM idle.
    task automatic do_write(input int dut, input int idx, input logic [63:0] wd, input logic [63:0] ex);
        sb_t e;
        if (dut == 0) begin
            wdata0 = wd; en0 = 2'b01 << idx;
            e.sel = idx[0]; e.data = ex; sbq.push_back(e);
            exp_atp[idx] = ex;
        end else begin
            wdata1 = wd; en1 = 1'b1;
        end
        @(posedge regs_clk); #1;
        en0 = '0; en1 = '0;
        if (dut == 0) begin
            chk("req_rise", {63'b0, req0}, 64'd1);
            chk("satp", val0[63:0], exp_atp[0]);
            chk("vsatp", val0[127:64], exp_atp[1]);
            chk("dtu_satp", satp0, exp_atp[0]);
        end else begin
            chk("u1_req", {63'b0, req1}, 64'd1);
            chk("u1_data", data1, ex);
            chk("u1_satp", val1, ex);
        end
        @(posedge regs_clk); #1;
        chk("req_fall", {63'b0, dut == 0 ? req0 : req1}, 64'd0);
    endtask

    initial begin
        int scnt;
        sb_t e;
        vt[0] = '{0, 0, 64'h8000_1234_0000_0ABC, 64'h8000_1234_0000_0ABC};
        vt[1] = '{0, 0, 64'h5ABC_DEF0_1234_5678, 64'h8ABC_DEF0_1234_5678};
        vt[2] = '{0, 0, 64'h9111_2222_3333_4444, 64'h8111_2222_3333_4444};
        vt[3] = '{0, 1, 64'h0FFF_FFFF_FFFF_FFFF, 64'h0FFF_FFFF_FFFF_FFFF};
        vt[4] = '{0, 1, 64'hF000_0000_0000_0001, 64'h0000_0000_0000_0001};
        vt[5] = '{0, 0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        vt[6] = '{1, 0, 64'h9111_2222_3333_4444, 64'h9011_2000_0333_4444};
        vt[7] = '{1, 0, 64'h5FFF_FFFF_FFFF_FFFF, 64'h901F_F000_0FFF_FFFF};
        vt[8] = '{1, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};

        // Reset state, with smcir requested but MMU complete.
        smcir0 = 1'b1;
        #12;
        chk("rst_req", {63'b0, req0}, 64'd0);
        chk("rst_sel", {63'b0, sel0}, 64'd0);
        chk("rst_data", data0, 64'd0);
        chk("rst_atp_lo", val0[63:0], 64'd0);
        chk("rst_atp_hi", val0[127:64], 64'd0);
        chk("rst_stalls", {62'b0, astall0, sstall0}, 64'd0);
        smcir0 = 1'b0;
        #10 cpurst_b = 1'b1;
        @(posedge regs_clk); #1;

        for (int i = 0; i < 9; i++) do_write(vt[i].dut, vt[i].idx, vt[i].wdata, vt[i].exp);

        // Delayed ack with a vsatp write queued behind the satp update.
        ack0 = 1'b0;
        wdata0 = 64'h8123_4567_89AB_CDEF; en0 = 2'b01;
        e.sel = 1'b0; e.data = 64'h8123_4567_89AB_CDEF; sbq.push_back(e);
        @(posedge regs_clk); #1;
        exp_atp[0] = 64'h8123_4567_89AB_CDEF;
        chk("d_req", {63'b0, req0}, 64'd1);
        wdata0 = 64'h8000_00AB_CDEF_0123; en0 = 2'b10;
        e.sel = 1'b1; e.data = 64'h8000_00AB_CDEF_0123; sbq.push_back(e);
        scnt = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (astall0) scnt++;
            chk("d_vsatp_hold", val0[127:64], exp_atp[1]);
            if (k == 3) ack0 = 1'b1;
            @(posedge regs_clk); #1;
        end
        #1;
        if (astall0) scnt++;
        chk("d_stall_cycles", 64'(scnt), 64'd4);
        chk("d_idle", {63'b0, req0}, 64'd0);
        chk("d_vsatp_still", val0[127:64], exp_atp[1]);
        ack0 = 1'b0;
        @(posedge regs_clk); #1;
        exp_atp[1] = 64'h8000_00AB_CDEF_0123;
        chk("d_vsatp_commit", val0[127:64], exp_atp[1]);
        chk("d_satp_kept", val0[63:0], exp_atp[0]);
        chk("d_req2", {63'b0, req0}, 64'd1);
        chk("d_sel2", {63'b0, sel0}, 64'd1);
        en0 = '0; ack0 = 1'b1;
        @(posedge regs_clk); #1;
        chk("d_req2_fall", {63'b0, req0}, 64'd0);

        // smcir gating.
        ack0 = 1'b0; smcir0 = 1'b1; cmplt0 = 1'b1; #1;
        chk("s_idle_cmplt", {63'b0, sstall0}, 64'd0);
        cmplt0 = 1'b0; #1;
        chk("s_idle_busy", {63'b0, sstall0}, 64'd1);
        cmplt0 = 1'b1;
        wdata0 = 64'h8000_0000_0000_0055; en0 = 2'b01;
        e.sel = 1'b0; e.data = 64'h8000_0000_0000_0055; sbq.push_back(e);
        @(posedge regs_clk); #1;
        exp_atp[0] = 64'h8000_0000_0000_0055;
        en0 = '0; #1;
        chk("s_req", {63'b0, sstall0}, 64'd1);
        ack0 = 1'b1;
        @(posedge regs_clk); #1;
        chk("s_after", {63'b0, sstall0}, 64'd0);
        smcir0 = 1'b0;

        // Asynchronous reset with an update outstanding.
        ack0 = 1'b0;
        wdata0 = 64'h8765_4321_0FED_CBA9; en0 = 2'b10;
        e.sel = 1'b1; e.data = 64'h8765_4321_0FED_CBA9; sbq.push_back(e);
        @(posedge regs_clk); #1;
        en0 = '0;
        chk("r_req", {63'b0, req0}, 64'd1);
        #2 cpurst_b = 1'b0;
        #1;
        chk("r_req_drop", {63'b0, req0}, 64'd0);
        chk("r_atp_lo", val0[63:0], 64'd0);
        chk("r_atp_hi", val0[127:64], 64'd0);
        chk("r_data", data0, 64'd0);
        chk("r_u1", val1, 64'd0);
        sbq.delete();
        exp_atp[0] = '0; exp_atp[1] = '0;
        #3 cpurst_b = 1'b1;
        ack0 = 1'b1;
        @(posedge regs_clk); #1;
        do_write(0, 1, 64'h8000_0042_0000_0777, 64'h8000_0042_0000_0777);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
